systolic_drv: RTL and testbench

Sequential initiator for the combinational NOR systolic array. It accepts a single test vector, or a sweep command, through a valid/ready handshake. It drives the array's row and column inputs from registers and waits a programmable settle time. It then samples the array output and returns each result, with the applied vector, through a second valid/ready handshake.

---
 rtl/systolic_pkg.sv | 51 +++++
 rtl/systolic_ref.sv | 18 +
 rtl/systolic_drv.sv | 142 ++++++++++++++
 tb/tb_systolic_drv.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the NOR systolic array initiator.
//   - drvState_e : initiator FSM states
//   - ROW_DEF / COL_DEF : default array dimensions
//   - MAX_DIM : widest row/column the golden function handles
//   - systolic_nor() : golden model of the combinational NOR grid
package systolic_pkg;

  localparam int unsigned ROW_DEF = 4;
  localparam int unsigned COL_DEF = 9;
  localparam int unsigned MAX_DIM = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RESP
  } drvState_e;

  // Grid recurrence w[i][j] = ~(w[i][j-1] | w[i-1][j]) with boundaries
  // w[i][0] = row[i-1] and w[0][j] = col[j-1]; returns w[nRow][nCol].
  // Evaluated one grid row at a time: w holds the row above, left the
  // running west input.
  function automatic logic systolic_nor(
    input logic [MAX_DIM-1:0] row,
    input logic [MAX_DIM-1:0] col,
    input int unsigned        nRow = ROW_DEF,
    input int unsigned        nCol = COL_DEF
  );
    logic [MAX_DIM:0] w;
    logic             left;
    w    = '0;
    left = 1'b0;
    for (int unsigned j = 1; j <= MAX_DIM; j++) begin
      w[j] = col[j-1];
    end
    for (int unsigned i = 1; i <= MAX_DIM; i++) begin
      if (i <= nRow) begin
        left = row[i-1];
        for (int unsigned j = 1; j <= MAX_DIM; j++) begin
          if (j <= nCol) begin
            left = ~(left | w[j]);
            w[j] = left;
          end
        end
      end
    end
    return w[nCol];
  endfunction

endpackage

// File: rtl/systolic_ref.sv
// systolic_ref: combinational golden NOR-grid model.
//   row    in  ROW     array row inputs
//   col    in  COLUMN  array column inputs
//   result out 1       expected array output
module systolic_ref
  import systolic_pkg::*;
#(
  parameter int unsigned ROW    = ROW_DEF,
  parameter int unsigned COLUMN = COL_DEF
) (
  input  logic [ROW-1:0]    row,
  input  logic [COLUMN-1:0] col,
  output logic              result
);

  assign result = systolic_nor(MAX_DIM'(row), MAX_DIM'(col), ROW, COLUMN);

endmodule

// File: rtl/systolic_drv.sv
// systolic_drv: sequential initiator for the combinational NOR systolic array.
// Accepts a single vector or an exhaustive sweep command, drives the array
// from registers, waits SETTLE cycles, samples arr_out and returns each
// result with its applied vector.
//   clk, reset           clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_sweep, cmd_row, cmd_col payload
//   arr_row, arr_col     registered array drive; arr_out array result
//   rsp_valid/rsp_ready  response handshake
//   rsp_vec              applied vector {row, col}
//   rsp_out, rsp_last    sampled result, final response of the command
//   rsp_err              golden-model mismatch (0 unless SYSTOLIC_DRV_CHECK_EN)
//   busy                 FSM not idle
// Build option: define SYSTOLIC_DRV_CHECK_EN to instantiate the golden model.
module systolic_drv
  import systolic_pkg::*;
#(
  parameter int unsigned ROW    = ROW_DEF,
  parameter int unsigned COLUMN = COL_DEF,
  parameter int unsigned SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_sweep,
  input  logic [ROW-1:0]        cmd_row,
  input  logic [COLUMN-1:0]     cmd_col,
  output logic [ROW-1:0]        arr_row,
  output logic [COLUMN-1:0]     arr_col,
  input  logic                  arr_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ROW+COLUMN-1:0] rsp_vec,
  output logic                  rsp_out,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned VW        = ROW + COLUMN;
  localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);

  drvState_e     state, stateNext;
  logic [7:0]    cnt;
  logic [VW-1:0] vec;
  logic          sweepMode;
  logic          rspOut;
  logic          rspLast;
  logic          cmdFire;
  logic          rspFire;

  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign cmdFire   = cmd_valid && cmd_ready;
  assign rspFire   = rsp_valid && rsp_ready;

  // The vector register is both the array drive and the reported vector.
  assign arr_row  = vec[VW-1:COLUMN];
  assign arr_col  = vec[COLUMN-1:0];
  assign rsp_vec  = vec;
  assign rsp_out  = rspOut;
  assign rsp_last = rspLast;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // cnt counts the cycles left before the sample cycle; it is loaded as the
  // vector is launched so that the sample cycle lands SETTLE cycles after
  // the vector first appears on arr_*.
  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE:   if (cmdFire) stateNext = ST_DRIVE;
      ST_DRIVE:  stateNext = (cnt <= 8'd1) ? ST_SAMPLE : ST_SETTLE;
      ST_SETTLE: if (cnt <= 8'd1) stateNext = ST_SAMPLE;
      ST_SAMPLE: stateNext = ST_RESP;
      ST_RESP:   if (rspFire) stateNext = rspLast ? ST_IDLE : ST_DRIVE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec       <= '0;
      cnt       <= '0;
      sweepMode <= 1'b0;
      rspOut    <= 1'b0;
      rspLast   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmdFire) begin
            sweepMode <= cmd_sweep;
            vec       <= cmd_sweep ? '0 : {cmd_row, cmd_col};
            cnt       <= SETTLE_M1;
          end
        end
        ST_DRIVE, ST_SETTLE: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        ST_SAMPLE: begin
          rspOut  <= arr_out;
          rspLast <= !sweepMode || (&vec);
        end
        ST_RESP: begin
          if (rspFire && !rspLast) begin
            vec <= vec + 1'b1;
            cnt <= SETTLE_M1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SYSTOLIC_DRV_CHECK_EN
  logic expected;
  logic rspErr;

  systolic_ref #(
    .ROW   (ROW),
    .COLUMN(COLUMN)
  ) uRef (
    .row   (vec[VW-1:COLUMN]),
    .col   (vec[COLUMN-1:0]),
    .result(expected)
  );

  always_ff @(posedge clk) begin
    if (reset)                   rspErr <= 1'b0;
    else if (state == ST_SAMPLE) rspErr <= (arr_out != expected);
  end

  assign rsp_err = rspErr;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_drv.sv
// tb_systolic_drv: directed bench for systolic_drv with a response scoreboard.
// The array model returns the inverted result until a vector has been stable
// for SETTLE cycles, so sampling too early shows up as a wrong rsp_out.
module tb_systolic_drv;
  import systolic_pkg::*;

  localparam int unsigned ROW    = 4;
  localparam int unsigned COLUMN = 9;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned VW     = ROW + COLUMN;
`ifdef SYSTOLIC_DRV_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_sweep;
  logic [ROW-1:0]    cmd_row;
  logic [COLUMN-1:0] cmd_col;
  logic [ROW-1:0]    arr_row;
  logic [COLUMN-1:0] arr_col;
  logic              arr_out = 1'b0;
  logic              rsp_valid, rsp_ready;
  logic [VW-1:0]     rsp_vec;
  logic              rsp_out, rsp_last, rsp_err, busy;

  systolic_drv #(
    .ROW   (ROW),
    .COLUMN(COLUMN),
    .SETTLE(SETTLE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_sweep(cmd_sweep),
    .cmd_row  (cmd_row),
    .cmd_col  (cmd_col),
    .arr_row  (arr_row),
    .arr_col  (arr_col),
    .arr_out  (arr_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_vec  (rsp_vec),
    .rsp_out  (rsp_out),
    .rsp_last (rsp_last),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int respCount = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Array model with settle behaviour.
  bit            forceOne = 1'b0;
  logic [VW-1:0] lastVec  = '0;
  int unsigned   age      = 1000;
  logic          modelOut;
  always @(negedge clk) begin
    if ({arr_row, arr_col} !== lastVec) begin
      lastVec = {arr_row, arr_col};
      age     = 1;
    end else if (age < 1000) begin
      age++;
    end
    modelOut = systolic_nor(MAX_DIM'(arr_row), MAX_DIM'(arr_col), ROW, COLUMN);
    arr_out  = forceOne ? 1'b1 : ((age >= SETTLE) ? modelOut : ~modelOut);
  end

  typedef struct packed {
    logic [VW-1:0] vec;
    logic          out;
    logic          last;
    logic          err;
  } exp_t;
  exp_t q[$];

  function automatic exp_t mkExp(input logic [VW-1:0] v, input bit last, input bit forced);
    exp_t             e;
    logic [ROW-1:0]   r;
    logic [COLUMN-1:0] c;
    logic             g;
    r      = v[VW-1:COLUMN];
    c      = v[COLUMN-1:0];
    g      = systolic_nor(MAX_DIM'(r), MAX_DIM'(c), ROW, COLUMN);
    e.vec  = v;
    e.out  = forced ? 1'b1 : g;
    e.last = last;
    e.err  = CHECK && (e.out != g);
    return e;
  endfunction

  // Response monitor: every accepted response is checked against the queue.
  exp_t monE;
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      respCount++;
      chk("scoreboard_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        monE = q.pop_front();
        chk("rsp_vec",  32'(rsp_vec),  32'(monE.vec));
        chk("rsp_out",  32'(rsp_out),  32'(monE.out));
        chk("rsp_last", 32'(rsp_last), 32'(monE.last));
        chk("rsp_err",  32'(rsp_err),  32'(monE.err));
      end
    end
  end

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic sendCmd(input bit sw, input logic [ROW-1:0] r, input logic [COLUMN-1:0] c);
    int n;
    cmd_valid = 1'b1;
    cmd_sweep = sw;
    cmd_row   = r;
    cmd_col   = c;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < limit), 32'd1);
  endtask

  task automatic setReady(input bit v);
    @(posedge clk);
    #1 rsp_ready = v;
  endtask

  task automatic singleZeroTest(input string tag);
    int lat;
    q.push_back(mkExp('0, 1'b1, 1'b0));
    sendCmd(1'b0, '0, '0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'(SETTLE + 1));
    waitDrain(50);
    chk({tag, "_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $error("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] snap;
  int          n0;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_sweep = 1'b0;
    cmd_row   = '0;
    cmd_col   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_arr",       32'({arr_row, arr_col}), 32'd0);
    chk("rst_rsp",       32'({rsp_vec, rsp_out, rsp_last, rsp_err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single vector 0, latency and fields
    singleZeroTest("single0");

    // Forced arr_out=1 on vector 0
    forceOne = 1'b1;
    @(negedge clk);
    q.push_back(mkExp('0, 1'b1, 1'b1));
    sendCmd(1'b0, '0, '0);
    waitDrain(50);
    forceOne = 1'b0;
    @(negedge clk);

    // Full sweep with a 10-cycle backpressure window
    for (int unsigned v = 0; v < (1 << VW); v++)
      q.push_back(mkExp(VW'(v), v == (1 << VW) - 1, 1'b0));
    n0 = respCount;
    sendCmd(1'b1, 4'hA, 9'h155);
    repeat (100) @(negedge clk);
    setReady(1'b0);
    n0 = n0;
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    snap = 32'({rsp_vec, rsp_out, rsp_last, rsp_err, arr_row, arr_col});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", 32'({rsp_vec, rsp_out, rsp_last, rsp_err, arr_row, arr_col}), snap);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    end
    setReady(1'b1);
    waitDrain(45000);
    chk("sweep_count", 32'(respCount - n0), 32'(1 << VW));
    chk("sweep_idle", 32'(cmd_ready), 32'd1);
    chk("sweep_arr_hold", 32'({arr_row, arr_col}), 32'((1 << VW) - 1));

    // Command while busy
    setReady(1'b0);
    @(negedge clk);
    q.push_back(mkExp({4'h5, 9'h0A3}, 1'b1, 1'b0));
    sendCmd(1'b0, 4'h5, 9'h0A3);
    @(negedge clk);
    @(negedge clk);
    q.push_back(mkExp({4'h3, 9'h1FF}, 1'b1, 1'b0));
    cmd_valid = 1'b1;
    cmd_sweep = 1'b0;
    cmd_row   = 4'h3;
    cmd_col   = 9'h1FF;
    for (int i = 0; i < 6; i++) begin
      chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    chk("busy_held_rsp", 32'(rsp_valid), 32'd1);
    setReady(1'b1);
    @(negedge clk);
    chk("busy_before_hs", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("busy_after_hs", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    waitDrain(50);

    // Reset in the middle of a sweep
    @(negedge clk);
    for (int unsigned v = 0; v < (1 << VW); v++)
      q.push_back(mkExp(VW'(v), v == (1 << VW) - 1, 1'b0));
    sendCmd(1'b1, '0, '0);
    repeat (57) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_arr",       32'({arr_row, arr_col}), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    singleZeroTest("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
